spi_st7735_tx_master: RTL and testbench

//  SPI master transmitter for the ST7735R-style display link: serializes command bytes,
//  8-bit parameter bytes and 16-bit RGB565 pixels onto SPI_CLK/SPI_CS/SPI_MOSI/DC.

---
 rtl/spi_tx_pkg.sv | 42 ++++
 rtl/spi_tx_halfper_tick.sv | 29 ++
 rtl/spi_st7735_tx_master.sv | 151 +++++++++++++++
 tb/tb_spi_st7735_tx_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// Shared types and constants for the ST7735R SPI transmitter.
package spi_tx_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StShiftH,
      StShiftL,
      StGap
   } tx_state_e;

   typedef enum logic [1:0] {
      KindCmd,
      KindData8,
      KindPixel
   } tx_kind_e;

   localparam int unsigned BitCntW = 5;

   localparam logic [7:0] OpNop     = 8'h00;
   localparam logic [7:0] OpSwreset = 8'h01;
   localparam logic [7:0] OpDispoff = 8'h28;
   localparam logic [7:0] OpDispon  = 8'h29;
   localparam logic [7:0] OpCaset   = 8'h2A;
   localparam logic [7:0] OpRaset   = 8'h2B;
   localparam logic [7:0] OpRamwr   = 8'h2C;

   // Command wins when both kind flags are set.
   function automatic tx_kind_e decode_kind(input logic is_cmd, input logic is_pixel);
      if (is_cmd) begin
         return KindCmd;
      end else if (is_pixel) begin
         return KindPixel;
      end
      return KindData8;
   endfunction

   function automatic logic [BitCntW-1:0] kind_bits(input tx_kind_e kind);
      return (kind == KindPixel) ? BitCntW'(16) : BitCntW'(8);
   endfunction

endpackage

// File: rtl/spi_tx_halfper_tick.sv
// Half-period divider: counts 0..HALF_PERIOD-1, wraps, ticks on the last count.
module spi_tx_halfper_tick #(
   parameter int unsigned HALF_PERIOD = 2
) (
   input  logic mco,
   input  logic rst_n,
   input  logic i_restart,
   output logic o_tick
);

   localparam logic [7:0] LastCnt = 8'(HALF_PERIOD - 1);

   logic [7:0] r_cnt;
   logic       w_last;

   assign w_last = (r_cnt == LastCnt);
   assign o_tick = w_last;

   always_ff @(posedge mco) begin
      if (!rst_n) begin
         r_cnt <= 8'd0;
      end else if (i_restart || w_last) begin
         r_cnt <= 8'd0;
      end else begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/spi_st7735_tx_master.sv
// SPI mode-0 transmitter for ST7735R command/data/pixel transfers.
// Optional SPI_TX_CS_HOLD_EN: back-to-back transfers keep CS low and skip the gap.
module spi_st7735_tx_master
   import spi_tx_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 2,
   parameter int unsigned CS_GAP      = 2
) (
   input  logic        mco,
   input  logic        rst_n,
   input  logic [15:0] i_tx_data,
   input  logic        i_tx_is_cmd,
   input  logic        i_tx_is_pixel,
   input  logic        i_tx_valid,
   output logic        o_tx_ready,
   output logic        o_done_pls,
   output logic        SPI_CLK,
   output logic        SPI_CS,
   output logic        SPI_MOSI,
   output logic        DC
);

   localparam logic [7:0] GapLast = 8'(CS_GAP - 1);

   tx_state_e          r_state;
   tx_state_e          w_state_nxt;
   logic [15:0]        r_shift;
   logic               r_dc;
   logic [BitCntW-1:0] r_bit_cnt;
   logic [7:0]         r_gap_cnt;
   logic               r_done;

   logic     w_tick;
   logic     w_restart;
   logic     w_load;
   logic     w_shift;
   logic     w_bit_dec;
   logic     w_done_nxt;
   logic     w_ready;
   logic     w_active;
   tx_kind_e w_kind;

   assign w_kind    = decode_kind(i_tx_is_cmd, i_tx_is_pixel);
   // Divider held at zero outside the bit-timed states so SETUP always starts aligned.
   assign w_restart = (r_state == StIdle) || (r_state == StGap);

   spi_tx_halfper_tick #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_tick (
      .mco       (mco),
      .rst_n     (rst_n),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_bit_dec   = 1'b0;
      w_done_nxt  = 1'b0;
      w_ready     = 1'b0;
      unique case (r_state)
         StIdle: begin
            w_ready = 1'b1;
            if (i_tx_valid) begin
               w_load      = 1'b1;
               w_state_nxt = StSetup;
            end
         end
         StSetup: begin
            if (w_tick) begin
               w_state_nxt = StShiftH;
            end
         end
         StShiftH: begin
            if (w_tick) begin
               w_shift     = 1'b1;
               w_state_nxt = StShiftL;
            end
         end
         StShiftL: begin
            if (w_tick) begin
               if (r_bit_cnt == BitCntW'(1)) begin
                  w_done_nxt  = 1'b1;
                  w_state_nxt = StGap;
`ifdef SPI_TX_CS_HOLD_EN
                  w_ready = 1'b1;
                  if (i_tx_valid) begin
                     w_load      = 1'b1;
                     w_state_nxt = StSetup;
                  end
`endif
               end else begin
                  w_bit_dec   = 1'b1;
                  w_state_nxt = StShiftH;
               end
            end
         end
         StGap: begin
            if (r_gap_cnt == GapLast) begin
               w_state_nxt = StIdle;
            end
         end
         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   always_ff @(posedge mco) begin
      if (!rst_n) begin
         r_state   <= StIdle;
         r_shift   <= 16'd0;
         r_dc      <= 1'b0;
         r_bit_cnt <= '0;
         r_gap_cnt <= 8'd0;
         r_done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_done  <= w_done_nxt;
         if (w_load) begin
            // Byte transfers are left-aligned so MOSI always comes from bit 15.
            r_shift   <= (w_kind == KindPixel) ? i_tx_data : {i_tx_data[7:0], 8'h00};
            r_dc      <= (w_kind != KindCmd);
            r_bit_cnt <= kind_bits(w_kind);
         end else begin
            if (w_shift) begin
               r_shift <= {r_shift[14:0], 1'b0};
            end
            if (w_bit_dec) begin
               r_bit_cnt <= r_bit_cnt - BitCntW'(1);
            end
         end
         if (r_state == StGap) begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
         end else begin
            r_gap_cnt <= 8'd0;
         end
      end
   end

   assign w_active   = (r_state == StSetup) || (r_state == StShiftH) || (r_state == StShiftL);
   assign SPI_CLK    = (r_state == StShiftH);
   assign SPI_CS     = ~w_active;
   assign SPI_MOSI   = w_active & r_shift[15];
   assign DC         = r_dc;
   assign o_tx_ready = w_ready;
   assign o_done_pls = r_done;

endmodule

// File: tb/tb_spi_st7735_tx_master.sv
// Bench for spi_st7735_tx_master: two instances (HALF_PERIOD/CS_GAP = 2/2 and 1/1).
module tb_spi_st7735_tx_master;
   import spi_tx_pkg::*;

   logic mco = 1'b0;
   always #5 mco = ~mco;

   logic [1:0]  rst_n  = 2'b00;
   logic [1:0]  valid  = 2'b00;
   logic [1:0]  is_cmd = 2'b00;
   logic [1:0]  is_pix = 2'b00;
   logic [15:0] tx_data [2];
   logic [1:0]  ready, done, sck, cs, mosi, dc;

   int          rises    [2];
   int          dones    [2];
   int          cs_rises [2];
   int          viol     [2];
   int          hi_run   [2];
   int          last_gap [2];
   bit [63:0]   acc      [2];
   bit          last_dc  [2];
   bit          p_sck    [2];
   bit          p_mosi   [2];
   bit          p_cs     [2];
   bit          p_dc     [2];

   int n_checks = 0;
   int n_errors = 0;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int unsigned Hp  = (g == 0) ? 2 : 1;
      localparam int unsigned Gap = (g == 0) ? 2 : 1;

      spi_st7735_tx_master #(
         .HALF_PERIOD (Hp),
         .CS_GAP      (Gap)
      ) u_dut (
         .mco           (mco),
         .rst_n         (rst_n[g]),
         .i_tx_data     (tx_data[g]),
         .i_tx_is_cmd   (is_cmd[g]),
         .i_tx_is_pixel (is_pix[g]),
         .i_tx_valid    (valid[g]),
         .o_tx_ready    (ready[g]),
         .o_done_pls    (done[g]),
         .SPI_CLK       (sck[g]),
         .SPI_CS        (cs[g]),
         .SPI_MOSI      (mosi[g]),
         .DC            (dc[g])
      );

      // Protocol monitor: sampled mid-cycle, far from the active edge.
      always @(negedge mco) begin
         if (sck[g] && !p_sck[g]) begin
            rises[g]   = rises[g] + 1;
            acc[g]     = {acc[g][62:0], mosi[g]};
            last_dc[g] = dc[g];
            if (cs[g]) viol[g] = viol[g] + 1;
         end
         if (sck[g] && p_sck[g] && (mosi[g] != p_mosi[g])) viol[g] = viol[g] + 1;
         if (!cs[g] && !p_cs[g] && (dc[g] != p_dc[g])) viol[g] = viol[g] + 1;
         if (cs[g] && mosi[g]) viol[g] = viol[g] + 1;
         if (done[g]) dones[g] = dones[g] + 1;
         if (cs[g] && !p_cs[g]) cs_rises[g] = cs_rises[g] + 1;
         if (cs[g]) begin
            hi_run[g] = hi_run[g] + 1;
         end else begin
            if (p_cs[g]) last_gap[g] = hi_run[g];
            hi_run[g] = 0;
         end
         p_sck[g]  = sck[g];
         p_mosi[g] = mosi[g];
         p_cs[g]   = cs[g];
         p_dc[g]   = dc[g];
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int hp_of(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   function automatic int gap_of(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   task automatic wait_ready(input int g);
      int cyc = 0;
      while (!ready[g] && cyc < 1000) begin
         @(negedge mco);
         cyc++;
      end
      check("wait_ready", 64'(ready[g]), 64'd1);
   endtask

   // One transfer checked against the reference rules: width, bit order, DC, latency, done.
   task automatic send(input int g, input bit c, input bit p, input logic [15:0] data,
                       input string tag);
      int          n, lat, r0, d0, exp_lat;
      logic [15:0] word;
      n    = (!c && p) ? 16 : 8;
      word = (n == 16) ? data : {8'h00, data[7:0]};
`ifdef SPI_TX_CS_HOLD_EN
      exp_lat = hp_of(g) * (1 + 2 * n) - 1;
`else
      exp_lat = hp_of(g) * (1 + 2 * n) + gap_of(g);
`endif
      wait_ready(g);
      r0         = rises[g];
      d0         = dones[g];
      tx_data[g] = data;
      is_cmd[g]  = c;
      is_pix[g]  = p;
      valid[g]   = 1'b1;
      @(negedge mco);
      valid[g] = 1'b0;
      lat      = 0;
      while (!ready[g] && lat < 1000) begin
         @(negedge mco);
         lat++;
      end
      repeat (2) @(negedge mco);
      check({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check({tag, " sck_rises"}, 64'(rises[g] - r0), 64'(n));
      check({tag, " bits"}, acc[g] & ((64'd1 << n) - 64'd1), 64'(word));
      check({tag, " dc"}, 64'(last_dc[g]), 64'(!c));
      check({tag, " done"}, 64'(dones[g] - d0), 64'd1);
   endtask

   logic [7:0] ops [7];

   initial begin
      int          n_acc, cyc, g, r0, d0, cr0;
      logic [15:0] pa, pb;
      logic        acc_now;
      logic [39:0] exp_seq;

      ops = '{OpNop, OpSwreset, OpDispoff, OpDispon, OpCaset, OpRaset, OpRamwr};
      tx_data[0] = 16'h0;
      tx_data[1] = 16'h0;
      repeat (3) @(negedge mco);
      check("reset0 outputs", 64'({cs[0], sck[0], mosi[0], dc[0], ready[0], done[0]}),
            64'b100010);
      check("reset1 outputs", 64'({cs[1], sck[1], mosi[1], dc[1], ready[1], done[1]}),
            64'b100010);
      rst_n = 2'b11;
      repeat (2) @(negedge mco);

      send(0, 1'b1, 1'b0, 16'h002C, "cmd_2c");
      send(0, 1'b0, 1'b1, 16'hF800, "pix_f800");
      send(0, 1'b0, 1'b0, 16'hC35A, "data_5a");
      send(0, 1'b1, 1'b1, 16'hAB29, "cmd_pix_both");
      send(1, 1'b1, 1'b0, 16'h002C, "hp1_cmd_2c");
      send(1, 1'b0, 1'b1, 16'h07E0, "hp1_pix");

      // Reset mid-shift aborts without a done pulse.
      wait_ready(0);
      tx_data[0] = 16'h00FF;
      is_cmd[0]  = 1'b1;
      is_pix[0]  = 1'b0;
      valid[0]   = 1'b1;
      @(negedge mco);
      valid[0] = 1'b0;
      repeat (7) @(negedge mco);
      d0       = dones[0];
      rst_n[0] = 1'b0;
      @(negedge mco);
      check("midreset outputs", 64'({cs[0], sck[0], mosi[0], ready[0], done[0]}), 64'b10010);
      rst_n[0] = 1'b1;
      repeat (4) @(negedge mco);
      check("midreset no_done", 64'(dones[0] - d0), 64'd0);

      for (int i = 0; i < 20; i++) begin
         logic c, p;
         logic [15:0] d;
         g = $urandom_range(0, 1);
         c = ($urandom_range(0, 2) == 0);
         p = ($urandom_range(0, 1) == 1);
         d = 16'($urandom);
         if (c) d[7:0] = ops[$urandom_range(0, 6)];
         send(g, c, p, d, $sformatf("rand%0d", i));
      end

      // Valid held across RAMWR and two pixels: one accept per opportunity.
      pa = 16'($urandom);
      pb = 16'($urandom);
      exp_seq = {OpRamwr, pa, pb};
      wait_ready(0);
      r0  = rises[0];
      d0  = dones[0];
      cr0 = cs_rises[0];
      tx_data[0] = {8'h00, OpRamwr};
      is_cmd[0]  = 1'b1;
      is_pix[0]  = 1'b0;
      valid[0]   = 1'b1;
      n_acc = 0;
      cyc   = 0;
      while (n_acc < 3 && cyc < 3000) begin
         acc_now = ready[0];
         @(negedge mco);
         cyc++;
         if (acc_now) begin
            n_acc++;
            tx_data[0] = (n_acc == 1) ? pa : pb;
            is_cmd[0]  = 1'b0;
            is_pix[0]  = 1'b1;
         end
      end
      valid[0] = 1'b0;
      cyc = 0;
      while (!(ready[0] && cs[0]) && cyc < 1000) begin
         @(negedge mco);
         cyc++;
      end
      repeat (3) @(negedge mco);
      check("seq accepts", 64'(n_acc), 64'd3);
      check("seq sck_rises", 64'(rises[0] - r0), 64'd40);
      check("seq bits", 64'(acc[0][39:0]), 64'(exp_seq));
      check("seq dones", 64'(dones[0] - d0), 64'd3);
`ifdef SPI_TX_CS_HOLD_EN
      check("seq cs_rises", 64'(cs_rises[0] - cr0), 64'd1);
`else
      check("seq cs_rises", 64'(cs_rises[0] - cr0), 64'd3);
      // GAP cycles plus the single IDLE accept cycle.
      check("seq cs_gap", 64'(last_gap[0]), 64'(gap_of(0) + 1));
`endif

      check("protocol0", 64'(viol[0]), 64'd0);
      check("protocol1", 64'(viol[1]), 64'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
